// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI mode-0 MISO receiver.
package spi_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    STALL,
    HOLD
  } state_e;

  localparam int unsigned CLK_DIV_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned LEN_W_DEF   = 8;

  // Mode 0: sck idles low; miso is sampled on the edge leaving the idle level.
  localparam logic SCK_IDLE     = 1'b0;
  localparam logic SAMPLE_LEVEL = 1'b0;
  localparam logic CS_ACTIVE    = 1'b0;

endpackage

// File: rtl/spi_sck_tick.sv
// sck half-period divider: tick_o marks the last clk cycle of each CLK_DIV-cycle half period.
module spi_sck_tick #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned    CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_miso_receiver.sv
// SPI mode-0 controller-side receiver: frames cs, drives sck, assembles words onto a valid/ready stream.
// Build option SPI_RX_LSB_FIRST_EN selects LSB-first shifting (default MSB first).
module spi_miso_receiver
  import spi_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              miso,
  output logic              sck,
  output logic              cs,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned   BW        = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BITS_FULL = BW'(DATA_W);

  state_e             state_q, state_d;
  logic               sck_q, sck_d;
  logic               cs_q, cs_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [BW-1:0]      bits_q, bits_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic               tick;
  logic               load;
  logic               div_en;
  logic               div_clr;

  assign div_en  = (state_q == SETUP) || (state_q == XFER) || (state_q == HOLD);
  assign div_clr = (state_q == IDLE);

  spi_sck_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .en_i   (div_en),
    .clr_i  (div_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    sck_d   = sck_q;
    cs_d    = cs_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    sh_d    = sh_q;
    bits_d  = bits_q;
    words_d = words_q;
    load    = 1'b0;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start && len != '0) begin
          words_d = len;
          bits_d  = '0;
          cs_d    = CS_ACTIVE;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (tick) begin
          if (sck_q == SAMPLE_LEVEL) begin
            sck_d  = ~sck_q;
`ifdef SPI_RX_LSB_FIRST_EN
            sh_d   = {miso, sh_q[DATA_W-1:1]};
`else
            sh_d   = {sh_q[DATA_W-2:0], miso};
`endif
            bits_d = bits_q + 1'b1;
          end else begin
            sck_d = SCK_IDLE;
            if (bits_q == BITS_FULL) begin
              bits_d = '0;
              if (!valid_q || data_ready) begin
                load = 1'b1;
              end else begin
                state_d = STALL;
              end
            end
          end
        end
      end
      STALL: begin
        if (data_ready) begin
          load = 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          cs_d    = ~CS_ACTIVE;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A load overrides the accept-clear above, so accept+load keeps valid high.
    if (load) begin
      dout_d  = sh_q;
      valid_d = 1'b1;
      words_d = words_q - 1'b1;
      state_d = (words_q == LEN_W'(1)) ? HOLD : XFER;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sck_q   <= SCK_IDLE;
      cs_q    <= ~CS_ACTIVE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      sh_q    <= '0;
      bits_q  <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      sck_q   <= sck_d;
      cs_q    <= cs_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      sh_q    <= sh_d;
      bits_q  <= bits_d;
      words_q <= words_d;
    end
  end

  assign sck        = sck_q;
  assign cs         = cs_q;
  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_miso_receiver.sv
// Directed bench for spi_miso_receiver with a mode-0 peripheral model driving miso.
module tb_spi_miso_receiver;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned LEN_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             miso;
  logic             sck;
  logic             cs;
  logic [DATA_W-1:0] data_out;
  logic             data_valid;
  logic             data_ready;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  spi_miso_receiver #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W),
    .LEN_W   (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .miso       (miso),
    .sck        (sck),
    .cs         (cs),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .done       (done)
  );

  int   n_vec = 0;
  int   n_err = 0;

  // Monitor / peripheral state, written only by the negedge process.
  int         cs_low_cyc = 0;
  int         done_cnt   = 0;
  int         valid_cyc  = 0;
  int         rise_cnt   = 0;
  int         hold_err   = 0;
  int         ncap       = 0;
  int         idx        = 0;
  logic [7:0] cap [0:63];
  logic       sck_prev   = 1'b0;
  logic       held_v     = 1'b0;
  logic [7:0] held       = '0;

  logic       line [0:63];

  always @(negedge clk) begin
    if (rst) begin
      sck_prev = 1'b0;
      idx      = 0;
      held_v   = 1'b0;
    end else begin
      if (!cs) cs_low_cyc++;
      if (done) done_cnt++;
      if (data_valid) valid_cyc++;
      if (data_valid && data_ready && ncap < 64) begin
        cap[ncap] = data_out;
        ncap++;
      end
      if (held_v && data_out !== held) hold_err++;
      held_v = data_valid && !data_ready;
      held   = data_out;
      if (cs) idx = 0;
      else if (sck && !sck_prev) begin
        rise_cnt++;
        idx++;
      end
      sck_prev = sck;
    end
    miso = line[idx & 63];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int k, input logic [7:0] w);
    for (int b = 0; b < 8; b++) begin
`ifdef SPI_RX_LSB_FIRST_EN
      line[k*8+b] = w[b];
`else
      line[k*8+b] = w[7-b];
`endif
    end
  endtask

  task automatic pulse_start(input logic [7:0] l);
    @(posedge clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge clk); #1;
    start = 1'b0;
    len   = '0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    #1;
    check({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  int b_cs, b_done, b_valid, b_rise, b_cap;

  task automatic snap();
    b_cs    = cs_low_cyc;
    b_done  = done_cnt;
    b_valid = valid_cyc;
    b_rise  = rise_cnt;
    b_cap   = ncap;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) line[i] = 1'b0;
    rst        = 1'b1;
    start      = 1'b0;
    len        = '0;
    data_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck",   32'(sck), 0);
    check("rst_cs",    32'(cs), 1);
    check("rst_dout",  32'(data_out), 0);
    check("rst_valid", 32'(data_valid), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    rst = 1'b0;

    // 1: single word
    set_word(0, 8'hA5);
    snap();
    pulse_start(8'd1);
    wait_done("t1", 200);
    check("t1_rises",  32'(rise_cnt - b_rise), 8);
    check("t1_nwords", 32'(ncap - b_cap), 1);
    check("t1_word",   32'(cap[b_cap]), 'hA5);
    check("t1_vcyc",   32'(valid_cyc - b_valid), 1);
    check("t1_cslow",  32'(cs_low_cyc - b_cs), 36);
    check("t1_ndone",  32'(done_cnt - b_done), 1);

    // 2: three-word burst, always ready
    set_word(0, 8'h01);
    set_word(1, 8'h80);
    set_word(2, 8'hFF);
    snap();
    pulse_start(8'd3);
    wait_done("t2", 500);
    check("t2_nwords", 32'(ncap - b_cap), 3);
    check("t2_w0",     32'(cap[b_cap]), 'h01);
    check("t2_w1",     32'(cap[b_cap+1]), 'h80);
    check("t2_w2",     32'(cap[b_cap+2]), 'hFF);
    check("t2_cslow",  32'(cs_low_cyc - b_cs), 100);
    check("t2_ndone",  32'(done_cnt - b_done), 1);

    // 3: back-pressure stalls after word 2
    set_word(0, 8'h01);
    set_word(1, 8'h02);
    data_ready = 1'b0;
    snap();
    pulse_start(8'd2);
    begin
      logic got_v;
      got_v = 1'b0;
      for (int i = 0; i < 200 && !got_v; i++) begin
        @(negedge clk);
        if (data_valid) got_v = 1'b1;
      end
      check("t3_first_valid", 32'(got_v), 1);
    end
    repeat (60) @(negedge clk);
    check("t3_stall_sck",   32'(sck), 0);
    check("t3_stall_cs",    32'(cs), 0);
    check("t3_stall_dout",  32'(data_out), 'h01);
    check("t3_stall_valid", 32'(data_valid), 1);
    check("t3_stall_rises", 32'(rise_cnt - b_rise), 16);
    @(posedge clk); #1;
    data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t3_load_dout",  32'(data_out), 'h02);
    check("t3_load_valid", 32'(data_valid), 1);
    wait_done("t3", 200);
    check("t3_nwords", 32'(ncap - b_cap), 2);
    check("t3_w0",     32'(cap[b_cap]), 'h01);
    check("t3_w1",     32'(cap[b_cap+1]), 'h02);
    check("t3_hold",   32'(hold_err), 0);

    // 4: reset mid-word, then a clean burst
    set_word(0, 8'h3C);
    set_word(1, 8'h55);
    snap();
    pulse_start(8'd2);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("t4_cs",    32'(cs), 1);
    check("t4_sck",   32'(sck), 0);
    check("t4_valid", 32'(data_valid), 0);
    check("t4_busy",  32'(busy), 0);
    rst = 1'b0;
    snap();
    pulse_start(8'd1);
    wait_done("t4", 200);
    check("t4_nwords", 32'(ncap - b_cap), 1);
    check("t4_word",   32'(cap[b_cap]), 'h3C);

    // 5: ignored starts
    snap();
    pulse_start(8'd0);
    repeat (5) @(negedge clk);
    check("t5_len0_busy", 32'(busy), 0);
    check("t5_len0_cs",   32'(cs), 1);
    check("t5_len0_cslow", 32'(cs_low_cyc - b_cs), 0);
    set_word(0, 8'h96);
    snap();
    pulse_start(8'd1);
    repeat (6) @(posedge clk);
    pulse_start(8'd5);
    @(negedge clk);
    check("t5_busy_kept", 32'(busy), 1);
    check("t5_cs_kept",   32'(cs), 0);
    wait_done("t5", 300);
    check("t5_nwords", 32'(ncap - b_cap), 1);
    check("t5_word",   32'(cap[b_cap]), 'h96);
    check("t5_cslow",  32'(cs_low_cyc - b_cs), 36);

    // 6: raw line bits 1,0,1,0,0,0,0,0
    for (int i = 0; i < 8; i++) line[i] = 1'b0;
    line[0] = 1'b1;
    line[2] = 1'b1;
    snap();
    pulse_start(8'd1);
    wait_done("t6", 200);
    check("t6_nwords", 32'(ncap - b_cap), 1);
`ifdef SPI_RX_LSB_FIRST_EN
    check("t6_order", 32'(cap[b_cap]), 'h05);
`else
    check("t6_order", 32'(cap[b_cap]), 'hA0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
